// File: rtl/uart_packet_bridge_pkg.sv
// Shared types and helpers for the UART packet bridge: FSM state encodings and
// the length-field width rule used by every parameter list in the bridge.
package uart_bridge_pkg;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_FILL,
    RX_COMMIT
  } rx_state_e;

  // Bits needed to hold any count from 0 up to and including max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/uart_packet_bridge_if.sv
// Bundle of every handshake/bus signal of the bridge: the wide-word TX/RX queue
// ports and the byte-serial UART ports. slave = bridge view, master = environment.
interface uart_packet_bridge_if
  import uart_bridge_pkg::*;
#(
  parameter int TX_BYTES = 24,
  parameter int RX_BYTES = 16,
  parameter int DEPTH    = 4,
  parameter int TXL_W    = len_width(TX_BYTES),
  parameter int RXL_W    = len_width(RX_BYTES),
  parameter int LVL_W    = len_width(DEPTH)
) ();

  logic                    tx_push;
  logic [TX_BYTES*8-1:0]   tx_data;
  logic [TXL_W-1:0]        tx_len;
  logic                    tx_ready;
  logic                    tx_byte_valid;
  logic [7:0]              tx_byte;
  logic                    tx_byte_ready;
  logic [LVL_W-1:0]        tx_level;

  logic                    rx_byte_valid;
  logic [7:0]              rx_byte;
  logic                    rx_byte_ready;
  logic                    rx_flush;
  logic                    rx_valid;
  logic [RX_BYTES*8-1:0]   rx_data;
  logic [RXL_W-1:0]        rx_len;
  logic                    rx_pop;
  logic [LVL_W-1:0]        rx_level;

  modport slave (
    input  tx_push, tx_data, tx_len, tx_byte_ready,
    input  rx_byte_valid, rx_byte, rx_flush, rx_pop,
    output tx_ready, tx_byte_valid, tx_byte, tx_level,
    output rx_byte_ready, rx_valid, rx_data, rx_len, rx_level
  );

  modport master (
    output tx_push, tx_data, tx_len, tx_byte_ready,
    output rx_byte_valid, rx_byte, rx_flush, rx_pop,
    input  tx_ready, tx_byte_valid, tx_byte, tx_level,
    input  rx_byte_ready, rx_valid, rx_data, rx_len, rx_level
  );

endinterface

// File: rtl/uart_packet_bridge_queue.sv
// Packet FIFO with wrap-bit pointers and a combinational head read, so the
// consumer sees the oldest entry in the same cycle it becomes non-empty.
module packet_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_reg, wr_ptr_next;
  logic [AW:0]  rd_ptr_reg, rd_ptr_next;
  logic [W-1:0] mem [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign level   = LVL_W'(wr_ptr_reg - rd_ptr_reg);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage is never reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_packet_bridge.sv
// Packet bridge between a wide-word processor port and a byte-serial UART:
// TX queue + LSB-first serialiser, RX packer with idle timeout + RX queue.
module uart_packet_bridge
  import uart_bridge_pkg::*;
#(
  parameter int TX_BYTES = 24,
  parameter int RX_BYTES = 16,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 500000,
  parameter int TXL_W    = len_width(TX_BYTES),
  parameter int RXL_W    = len_width(RX_BYTES),
  parameter int LVL_W    = len_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_packet_bridge_if.slave bus
);

  localparam int TX_W  = TX_BYTES * 8;
  localparam int RX_W  = RX_BYTES * 8;
  localparam int TXQ_W = TX_W + TXL_W;
  localparam int RXQ_W = RX_W + RXL_W;
  localparam int TMR_W = $clog2(TIMEOUT);

  // ---------------- TX path ----------------
  tx_state_e        tx_state_reg, tx_state_next;
  logic [TXL_W-1:0] tx_idx_reg, tx_idx_next;
  logic [TXL_W-1:0] tx_len_clamped;
  logic             tx_q_push, tx_q_pop, tx_full, tx_empty;
  logic [TXQ_W-1:0] tx_head;
  logic [TXL_W-1:0] tx_head_len;
  logic [7:0]       tx_lane [TX_BYTES];
  logic [7:0]       tx_sel;

  assign tx_len_clamped = (bus.tx_len > TXL_W'(TX_BYTES)) ? TXL_W'(TX_BYTES) : bus.tx_len;
  assign tx_q_push      = bus.tx_push && (bus.tx_len != '0);
  assign bus.tx_ready   = !tx_full;

  packet_queue #(
    .W     (TXQ_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_tx_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_q_push),
    .push_data ({tx_len_clamped, bus.tx_data}),
    .pop       (tx_q_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (bus.tx_level)
  );

  assign tx_head_len = tx_head[TXQ_W-1 -: TXL_W];

  genvar gi;
  generate
    for (gi = 0; gi < TX_BYTES; gi++) begin : g_tx_lane
      assign tx_lane[gi] = tx_head[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_idx_next   = tx_idx_reg;
    tx_q_pop      = 1'b0;
    tx_sel        = '0;
    for (int i = 0; i < TX_BYTES; i++) begin
      if (tx_idx_reg == TXL_W'(i)) tx_sel = tx_lane[i];
    end
    case (tx_state_reg)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_state_next = TX_SEND;
          tx_idx_next   = '0;
        end
      end
      TX_SEND: begin
        if (bus.tx_byte_ready) begin
          if (tx_idx_reg == tx_head_len - TXL_W'(1)) begin
            tx_q_pop      = 1'b1;
            tx_state_next = TX_IDLE;
          end else begin
            tx_idx_next = tx_idx_reg + TXL_W'(1);
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_idx_reg   <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_idx_reg   <= tx_idx_next;
    end
  end

  assign bus.tx_byte_valid = (tx_state_reg == TX_SEND);
  assign bus.tx_byte       = bus.tx_byte_valid ? tx_sel : 8'h00;

  // ---------------- RX path ----------------
  rx_state_e        rx_state_reg, rx_state_next;
  logic [RX_W-1:0]  stage_reg, stage_next;
  logic [RXL_W-1:0] cnt_reg, cnt_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [RX_W-1:0]  stage_written;
  logic [RXL_W-1:0] cnt_plus;
  logic             rx_accept, rx_q_push, rx_full, rx_empty;
  logic [RXQ_W-1:0] rx_head;

  assign bus.rx_byte_ready = (rx_state_reg != RX_COMMIT);
  assign rx_accept         = bus.rx_byte_valid && bus.rx_byte_ready;
  assign cnt_plus          = cnt_reg + RXL_W'(1);

  // Incoming byte lands in the lane selected by the current count.
  generate
    for (gi = 0; gi < RX_BYTES; gi++) begin : g_rx_lane
      assign stage_written[8*gi +: 8] = (cnt_reg == RXL_W'(gi)) ? bus.rx_byte
                                                                  : stage_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    rx_state_next = rx_state_reg;
    stage_next    = stage_reg;
    cnt_next      = cnt_reg;
    timer_next    = timer_reg;
    rx_q_push     = 1'b0;
    case (rx_state_reg)
      RX_IDLE, RX_FILL: begin
        if (rx_accept) begin
          stage_next    = stage_written;
          cnt_next      = cnt_plus;
          timer_next    = '0;
          rx_state_next = ((cnt_plus == RXL_W'(RX_BYTES)) || bus.rx_flush) ? RX_COMMIT : RX_FILL;
        end else if (rx_state_reg == RX_FILL) begin
          if (bus.rx_flush || (timer_reg == TMR_W'(TIMEOUT - 1))) begin
            rx_state_next = RX_COMMIT;
          end else begin
            timer_next = timer_reg + TMR_W'(1);
          end
        end
      end
      RX_COMMIT: begin
        // Full is judged on the current pointers; a same-cycle pop helps next cycle.
        if (!rx_full) begin
          rx_q_push     = 1'b1;
          stage_next    = '0;
          cnt_next      = '0;
          timer_next    = '0;
          rx_state_next = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      stage_reg    <= '0;
      cnt_reg      <= '0;
      timer_reg    <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      stage_reg    <= stage_next;
      cnt_reg      <= cnt_next;
      timer_reg    <= timer_next;
    end
  end

  packet_queue #(
    .W     (RXQ_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_rx_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_q_push),
    .push_data ({cnt_reg, stage_reg}),
    .pop       (bus.rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (bus.rx_level)
  );

  assign bus.rx_valid = !rx_empty;
  assign bus.rx_data  = rx_empty ? '0 : rx_head[RX_W-1:0];
  assign bus.rx_len   = rx_empty ? '0 : rx_head[RXQ_W-1 -: RXL_W];

endmodule

// File: tb/tb_uart_packet_bridge.sv
// Randomised + directed bench for uart_packet_bridge, compared every cycle
// against a packet-level reference model built from byte queues.
module tb_uart_packet_bridge;
  import uart_bridge_pkg::*;

  localparam int TXB     = 24;
  localparam int RXB     = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int TXL_W   = len_width(TXB);
  localparam int RXL_W   = len_width(RXB);
  localparam int LVL_W   = len_width(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_packet_bridge_if #(.TX_BYTES(TXB), .RX_BYTES(RXB), .DEPTH(DEPTH)) bus ();

  uart_packet_bridge #(
    .TX_BYTES (TXB),
    .RX_BYTES (RXB),
    .DEPTH    (DEPTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: packets as byte queues plus length queues.
  logic [7:0] tx_bytes_q[$];
  int         tx_len_q[$];
  bit         tx_busy;
  logic [7:0] rx_stage_q[$];
  logic [7:0] rx_pend_q[$];
  bit         rx_pend;
  int         rx_idle;
  logic [7:0] rx_out_bytes[$];
  int         rx_out_len[$];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tx_bytes_q.delete(); tx_len_q.delete(); tx_busy = 1'b0;
    rx_stage_q.delete(); rx_pend_q.delete(); rx_pend = 1'b0; rx_idle = 0;
    rx_out_bytes.delete(); rx_out_len.delete();
  endtask

  task automatic idle_inputs();
    bus.tx_push = 1'b0; bus.tx_data = '0; bus.tx_len = '0; bus.tx_byte_ready = 1'b0;
    bus.rx_byte_valid = 1'b0; bus.rx_byte = '0; bus.rx_flush = 1'b0; bus.rx_pop = 1'b0;
  endtask

  function automatic logic [RXB*8-1:0] rx_head_exp();
    logic [RXB*8-1:0] d;
    d = '0;
    if (rx_out_len.size() > 0)
      for (int i = 0; i < rx_out_len[0]; i++) d[8*i +: 8] = rx_out_bytes[i];
    return d;
  endfunction

  task automatic check_all();
    check("tx_ready", 192'(bus.tx_ready), 192'(tx_len_q.size() < DEPTH));
    check("tx_level", 192'(bus.tx_level), 192'(tx_len_q.size()));
    check("tx_byte_valid", 192'(bus.tx_byte_valid), 192'(tx_busy));
    check("tx_byte", 192'(bus.tx_byte), 192'(tx_busy ? tx_bytes_q[0] : 8'h00));
    check("rx_byte_ready", 192'(bus.rx_byte_ready), 192'(!rx_pend));
    check("rx_valid", 192'(bus.rx_valid), 192'(rx_out_len.size() > 0));
    check("rx_level", 192'(bus.rx_level), 192'(rx_out_len.size()));
    check("rx_len", 192'(bus.rx_len), 192'(rx_out_len.size() > 0 ? rx_out_len[0] : 0));
    check("rx_data", 192'(bus.rx_data), 192'(rx_head_exp()));
  endtask

  task automatic check_reset_outputs();
    check("rst_tx_ready", 192'(bus.tx_ready), 192'(1));
    check("rst_tx_byte_valid", 192'(bus.tx_byte_valid), 192'(0));
    check("rst_tx_byte", 192'(bus.tx_byte), 192'(0));
    check("rst_tx_level", 192'(bus.tx_level), 192'(0));
    check("rst_rx_byte_ready", 192'(bus.rx_byte_ready), 192'(1));
    check("rst_rx_valid", 192'(bus.rx_valid), 192'(0));
    check("rst_rx_data", 192'(bus.rx_data), 192'(0));
    check("rst_rx_len", 192'(bus.rx_len), 192'(0));
    check("rst_rx_level", 192'(bus.rx_level), 192'(0));
  endtask

  // Advance the model by one clock using the inputs currently driven, then
  // let the DUT take the same edge and compare at the following negedge.
  task automatic cycle();
    bit push_ok, pop_ok, commit_ok;
    int l;
    push_ok = bus.tx_push && (tx_len_q.size() < DEPTH) && (bus.tx_len != 0);
    if (tx_busy) begin
      if (bus.tx_byte_ready) begin
        void'(tx_bytes_q.pop_front());
        tx_len_q[0]--;
        if (tx_len_q[0] == 0) begin
          void'(tx_len_q.pop_front());
          tx_busy = 1'b0;
          $display("tx packet sent, %0d left queued", tx_len_q.size());
        end
      end
    end else if (tx_len_q.size() > 0) begin
      tx_busy = 1'b1;
    end
    if (push_ok) begin
      l = (int'(bus.tx_len) > TXB) ? TXB : int'(bus.tx_len);
      tx_len_q.push_back(l);
      for (int i = 0; i < l; i++) tx_bytes_q.push_back(bus.tx_data[8*i +: 8]);
    end

    pop_ok    = bus.rx_pop && (rx_out_len.size() > 0);
    commit_ok = rx_pend && (rx_out_len.size() < DEPTH);
    if (pop_ok) begin
      $display("rx packet popped len=%0d", rx_out_len[0]);
      for (int i = 0; i < rx_out_len[0]; i++) void'(rx_out_bytes.pop_front());
      void'(rx_out_len.pop_front());
    end
    if (rx_pend) begin
      if (commit_ok) begin
        rx_out_len.push_back(rx_pend_q.size());
        foreach (rx_pend_q[i]) rx_out_bytes.push_back(rx_pend_q[i]);
        rx_pend_q.delete();
        rx_pend = 1'b0;
      end
    end else if (bus.rx_byte_valid) begin
      rx_stage_q.push_back(bus.rx_byte);
      rx_idle = 0;
      if (rx_stage_q.size() == RXB || bus.rx_flush) begin
        rx_pend_q = rx_stage_q; rx_stage_q.delete(); rx_pend = 1'b1;
      end
    end else if (rx_stage_q.size() > 0) begin
      if (bus.rx_flush || rx_idle == TIMEOUT - 1) begin
        rx_pend_q = rx_stage_q; rx_stage_q.delete(); rx_pend = 1'b1;
      end else begin
        rx_idle++;
      end
    end

    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [TXB*8-1:0] td;
    int k;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // TX: 3-byte packet, bytes appear two cycles after the push.
    $display("directed: tx 3-byte packet");
    for (int j = 0; j < TXB / 4; j++) td[32*j +: 32] = $urandom();
    td[23:0] = 24'hCCBBAA;
    bus.tx_byte_ready = 1'b1; bus.tx_push = 1'b1; bus.tx_len = 3; bus.tx_data = td;
    cycle();
    bus.tx_push = 1'b0;
    check("tx_latency_valid", 192'(bus.tx_byte_valid), 192'(0));
    cycle(); check("tx_byte0", 192'(bus.tx_byte), 192'(8'hAA));
    cycle(); check("tx_byte1", 192'(bus.tx_byte), 192'(8'hBB));
    cycle(); check("tx_byte2", 192'(bus.tx_byte), 192'(8'hCC));
    cycle(); check("tx_after_level", 192'(bus.tx_level), 192'(0));

    // TX: fill the queue with the UART stalled; the fifth push is dropped.
    $display("directed: tx queue full");
    bus.tx_byte_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int j = 0; j < TXB / 4; j++) td[32*j +: 32] = $urandom();
      bus.tx_push = 1'b1; bus.tx_len = 5; bus.tx_data = td;
      cycle();
      if (p == 3) check("tx_full_ready", 192'(bus.tx_ready), 192'(0));
    end
    bus.tx_push = 1'b0;
    check("tx_drop_level", 192'(bus.tx_level), 192'(4));
    bus.tx_byte_ready = 1'b1;
    repeat (30) cycle();
    check("tx_drained_level", 192'(bus.tx_level), 192'(0));

    // RX: 16 back-to-back bytes close a full word.
    $display("directed: rx 16-byte word");
    for (int i = 0; i < RXB; i++) begin
      bus.rx_byte_valid = 1'b1; bus.rx_byte = 8'(i);
      cycle();
    end
    bus.rx_byte_valid = 1'b0;
    check("rx_commit_ready_low", 192'(bus.rx_byte_ready), 192'(0));
    cycle();
    check("rx_commit_ready_back", 192'(bus.rx_byte_ready), 192'(1));
    check("rx_word_valid", 192'(bus.rx_valid), 192'(1));
    check("rx_word_len", 192'(bus.rx_len), 192'(16));
    check("rx_word_top", 192'(bus.rx_data[127:120]), 192'(8'h0F));
    bus.rx_pop = 1'b1; cycle(); bus.rx_pop = 1'b0;

    // RX: 3 bytes then silence; timeout closes the packet.
    $display("directed: rx idle timeout");
    for (int i = 0; i < 3; i++) begin
      bus.rx_byte_valid = 1'b1; bus.rx_byte = 8'($urandom_range(1, 255));
      cycle();
    end
    bus.rx_byte_valid = 1'b0;
    k = 0;
    while (!bus.rx_valid && k < 20) begin cycle(); k++; end
    check("rx_timeout_cycles", 192'(k), 192'(TIMEOUT + 1));
    check("rx_timeout_len", 192'(bus.rx_len), 192'(3));
    check("rx_timeout_upper", 192'(bus.rx_data[127:24]), 192'(0));
    bus.rx_pop = 1'b1; cycle(); bus.rx_pop = 1'b0;

    // RX: queue full, the fifth packet waits in COMMIT until a pop.
    $display("directed: rx queue full stall");
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < RXB; i++) begin
        bus.rx_byte_valid = 1'b1; bus.rx_byte = 8'($urandom());
        cycle();
      end
      bus.rx_byte_valid = 1'b0;
      cycle();
    end
    repeat (3) cycle();
    check("rx_stall_ready", 192'(bus.rx_byte_ready), 192'(0));
    check("rx_stall_level", 192'(bus.rx_level), 192'(4));
    bus.rx_pop = 1'b1; cycle(); bus.rx_pop = 1'b0;
    check("rx_pop_still_stalled", 192'(bus.rx_byte_ready), 192'(0));
    check("rx_pop_level", 192'(bus.rx_level), 192'(3));
    cycle();
    check("rx_commit_done_ready", 192'(bus.rx_byte_ready), 192'(1));
    check("rx_commit_done_level", 192'(bus.rx_level), 192'(4));
    bus.rx_pop = 1'b1; repeat (4) cycle(); bus.rx_pop = 1'b0;
    check("rx_drained_valid", 192'(bus.rx_valid), 192'(0));

    // Reset in the middle of a TX packet (idx 5) and an RX packet (cnt 7).
    $display("directed: reset mid-packet");
    for (int j = 0; j < TXB / 4; j++) td[32*j +: 32] = $urandom();
    bus.tx_byte_ready = 1'b1; bus.tx_push = 1'b1; bus.tx_len = 24; bus.tx_data = td;
    for (int i = 0; i < 7; i++) begin
      bus.rx_byte_valid = 1'b1; bus.rx_byte = 8'($urandom());
      cycle();
      bus.tx_push = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    idle_inputs();
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (30) cycle();

    // Randomised traffic on both paths.
    $display("random traffic");
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int j = 0; j < TXB / 4; j++) td[32*j +: 32] = $urandom();
      bus.tx_push       = ($urandom_range(0, 3) == 0);
      bus.tx_len        = TXL_W'($urandom_range(0, 27));
      bus.tx_data       = td;
      bus.tx_byte_ready = ($urandom_range(0, 3) != 0);
      bus.rx_byte_valid = ($urandom_range(0, 9) < ((((cyc / 60) % 2) == 0) ? 8 : 1));
      bus.rx_byte       = 8'($urandom());
      bus.rx_flush      = ($urandom_range(0, 19) == 0);
      bus.rx_pop        = ($urandom_range(0, 2) == 0);
      cycle();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
